rib_rr_arbiter: RTL and testbench
=================================

Name: rib_rr_arbiter

Overview:
Registered bus arbiter that shares the RIB slave fabric between NUM_M masters: core data, core fetch, JTAG debug and UART download.
- Replaces fixed-priority selection with three mechanisms: priority classes, round-robin within the normal class, and a burst limit.
- Produces a one-hot grant and per-master hold flags. The hold flags feed core stall logic (hold_flag) and the debug masters.
- Sits between the master request lines and the RIB address/data mux, which selects on gnt_id_o.

Parameters:
NUM_M, 4, number of masters (2..8)
MAX_BURST, 4, consecutive granted cycles before forced rotation when others wait (>=1)
PRIO_MASK, 4'b1100, masters in the high-priority class (bit i = master i)

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
req_i  in  NUM_M  per-master request, level
lock_i  in  NUM_M  owner-held lock (atomic RMW); meaningful only for the current owner
gnt_o  out  NUM_M  one-hot registered grant, zero when idle
gnt_id_o  out  clog2(NUM_M)  index of owner, valid when gnt_valid_o
gnt_valid_o  out  1  some master granted
hold_o  out  NUM_M  combinational req_i & ~gnt_o
burst_cnt_o  out  clog2(MAX_BURST+1)  cycles the current owner has held the grant

Behaviour:
- Reset values: gnt_o=0, gnt_id_o=0, gnt_valid_o=0, burst_cnt_o=0, rr pointer ptr=0, state=IDLE. hold_o is forced to 0 while rst=1.
- Reset mid-grant drops the grant on the same edge. No grant is issued during the cycle rst is high.
- Latency: request in cycle t produces gnt_o in cycle t+1 when the fabric is free.
- Winner function win(req), where P = req & PRIO_MASK:
  - P!=0: lowest-index set bit of P.
  - Otherwise: first set bit of req scanning ptr, ptr+1, ... modulo NUM_M.
- States: IDLE, GRANT.
- IDLE:
  - req_i==0: stay in IDLE.
  - Otherwise: register gnt=win(req_i), burst_cnt=1, go to GRANT.
- GRANT (owner o): evaluated each cycle, in priority order:
  - (a) req_i[o]==0: release.
  - (b) lock_i[o]==1: keep o. burst_cnt saturates at MAX_BURST.
  - (c) o not in PRIO_MASK and (req_i & PRIO_MASK)!=0: preempt. The new owner is win(req_i with bit o cleared).
  - (d) burst_cnt==MAX_BURST and (req_i & ~(1<<o))!=0: rotate. The new owner is win(req_i with bit o cleared).
  - (e) Otherwise: keep o, burst_cnt+1 (saturating).
- On release, preempt or rotate:
  - ptr <= (o+1) mod NUM_M.
  - If another request exists, the new winner is registered on the same edge with zero bubble and burst_cnt=1.
  - If no other request exists, go to IDLE with gnt=0.
- A priority owner is never preempted by another priority master. It is rotated only by rule (d).
- Two priority masters requesting simultaneously: the lowest index wins. The ptr is not used for the priority class.
- Single requester: the burst limit never forces a release. burst_cnt saturates, and the grant holds indefinitely.
- Request withdrawn by a non-owner before grant: no effect, no grant issued.
- Lock held by a non-owner is ignored.
- ptr wrap: NUM_M-1 wraps to 0.
- gnt_o is always one-hot or zero. gnt_id_o holds its last value when idle.

Decomposition:
- Shared rib package/defines header: RIB_NUM_M, the master index constants (M_CORE_EX=0, M_CORE_PC=1, M_JTAG=2, M_UART_DBG=3), and the default PRIO_MASK.
- One sub-module: rr_pick. Combinational rotate-priority-encoder taking (req, ptr) and returning a one-hot and an index. It is reused for both the priority-class and round-robin picks.

Test Plan:
1. After reset, req_i=4'b0011 at t0 -> gnt_o=4'b0001 at t1. Hold req: at t4 (burst_cnt=4) rotate so gnt_o=4'b0010 at t5, ptr=1. hold_o[0]=1 thereafter.
2. Owner 0 with lock_i[0]=1 and req_i=4'b0111 for 10 cycles -> gnt_o stays 4'b0001, burst_cnt_o saturates at 4. lock low -> gnt_o=4'b0100 next cycle (priority master 2).
3. Owner 1 (normal class), req_i[3] rises at t -> gnt_o=4'b1000 at t+1 and ptr=2. req_i[2] and req_i[3] both rising from idle -> master 2 wins.
4. Round-robin fairness: all normal masters requesting continuously with PRIO_MASK=0 -> grant sequence 0,1,2,3,0 in 4-cycle slots with no idle cycle between owners.
5. Owner drops req_i while req_i=4'b0100 is pending -> next cycle gnt_o=4'b0100 with zero bubble. All requests dropped -> gnt_valid_o=0 next cycle.
6. rst asserted mid-grant (owner 2, burst_cnt=3) -> next cycle gnt_o=0, burst_cnt_o=0, hold_o=0. First grant after rst release follows ptr=0 ordering.

Source files
------------

// File: rtl/rib_rr_arbiter_pkg.sv
// rib_rr_arbiter_pkg: shared RIB master map, arbiter defaults and FSM state type.
package rib_rr_arbiter_pkg;
   localparam int RIB_NUM_M = 4;
   localparam int M_CORE_EX = 0;
   localparam int M_CORE_PC = 1;
   localparam int M_JTAG = 2;
   localparam int M_UART_DBG = 3;
   localparam int RIB_MAX_BURST = 4;
   localparam logic [RIB_NUM_M-1:0] RIB_PRIO_MASK = 4'b1100;
   typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/rib_rr_arbiter_rr_pick.sv
// rib_rr_arbiter_rr_pick: rotate-priority encoder, first set bit of req scanning from ptr upward.
module rib_rr_arbiter_rr_pick #(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   logic [2*N-1:0] dbl;
   int s;
   always_comb begin
      dbl = {req, req} >> ptr;
      s = 0;
      idx = '0;
      any = |req;
      // scan downward so the nearest set bit after ptr wins
      for (int k = N - 1; k >= 0; k--) begin
         if (dbl[k]) s = int'(ptr) + k;
      end
      idx = any ? IW'(s >= N ? s - N : s) : '0;
      onehot = any ? N'(1) << idx : '0;
   end
endmodule

// File: rtl/rib_rr_arbiter.sv
// rib_rr_arbiter: registered RIB bus arbiter with a priority class, round-robin
// among normal masters, owner lock and a burst limit that forces rotation.
module rib_rr_arbiter
   import rib_rr_arbiter_pkg::*;
#(
   parameter int NUM_M = RIB_NUM_M,
   parameter int MAX_BURST = RIB_MAX_BURST,
   parameter logic [NUM_M-1:0] PRIO_MASK = NUM_M'(RIB_PRIO_MASK),
   localparam int IW = $clog2(NUM_M),
   localparam int BW = $clog2(MAX_BURST + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NUM_M-1:0] req_i,
   input  logic [NUM_M-1:0] lock_i,
   output logic [NUM_M-1:0] gnt_o,
   output logic [IW-1:0]    gnt_id_o,
   output logic             gnt_valid_o,
   output logic [NUM_M-1:0] hold_o,
   output logic [BW-1:0]    burst_cnt_o
);
   arb_state_t state, state_n;
   logic [NUM_M-1:0] gnt_n, others, p_hot, r_hot;
   logic [IW-1:0] id_n, ptr, ptr_n, p_idx, r_idx, ptr_wrap;
   logic [BW-1:0] bc_n;
   logic p_any, r_any, owner_req, owner_lock, owner_prio, max_b, keep;

   // the current owner is excluded so a handover always lands on a different master
   assign others = state == GRANT ? req_i & ~gnt_o : req_i;

   rib_rr_arbiter_rr_pick #(.N(NUM_M)) u_prio (
      .req(others & PRIO_MASK), .ptr('0), .onehot(p_hot), .idx(p_idx), .any(p_any)
   );
   rib_rr_arbiter_rr_pick #(.N(NUM_M)) u_rr (
      .req(others), .ptr(ptr), .onehot(r_hot), .idx(r_idx), .any(r_any)
   );

   assign owner_req = |(req_i & gnt_o);
   assign owner_lock = |(lock_i & gnt_o);
   assign owner_prio = |(gnt_o & PRIO_MASK);
   assign max_b = burst_cnt_o == BW'(MAX_BURST);
   assign ptr_wrap = gnt_id_o == IW'(NUM_M - 1) ? '0 : gnt_id_o + 1'b1;
   assign keep = state == GRANT && owner_req &&
                 (owner_lock || !((!owner_prio && |(req_i & PRIO_MASK)) || (max_b && |others)));
   assign gnt_valid_o = state == GRANT;
   assign hold_o = rst ? '0 : req_i & ~gnt_o;

   always_comb begin
      state_n = state;
      gnt_n = gnt_o;
      id_n = gnt_id_o;
      bc_n = burst_cnt_o;
      ptr_n = ptr;
      if (keep) begin
         bc_n = max_b ? burst_cnt_o : burst_cnt_o + 1'b1;
      end else begin
         ptr_n = state == GRANT ? ptr_wrap : ptr;
         state_n = r_any ? GRANT : IDLE;
         gnt_n = r_any ? (p_any ? p_hot : r_hot) : '0;
         id_n = r_any ? (p_any ? p_idx : r_idx) : gnt_id_o;
         bc_n = r_any ? BW'(1) : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         gnt_o <= '0;
         gnt_id_o <= '0;
         burst_cnt_o <= '0;
         ptr <= '0;
      end else begin
         state <= state_n;
         gnt_o <= gnt_n;
         gnt_id_o <= id_n;
         burst_cnt_o <= bc_n;
         ptr <= ptr_n;
      end
   end
endmodule

// File: tb/tb_rib_rr_arbiter.sv
// tb_rib_rr_arbiter: scoreboard bench for the default arbiter and a PRIO_MASK=0 instance.
module tb_rib_rr_arbiter;
   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] id;
      logic       vld;
      logic [2:0] bc;
      logic [3:0] hold;
   } exp_t;

   localparam int MB = 4;

   logic clk, rst;
   logic [3:0] req_i, lock_i;
   logic [3:0] g0, g1, h0, h1;
   logic [1:0] id0, id1;
   logic v0, v1;
   logic [2:0] b0, b1;

   exp_t q0[$], q1[$];
   exp_t e;
   int vectors = 0, errors = 0;
   int own[2], cnt[2], ptr[2], lid[2];
   logic [3:0] mask[2];

   rib_rr_arbiter #(.NUM_M(4), .MAX_BURST(MB), .PRIO_MASK(4'b1100)) u_dut (
      .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .gnt_o(g0), .gnt_id_o(id0),
      .gnt_valid_o(v0), .hold_o(h0), .burst_cnt_o(b0)
   );
   rib_rr_arbiter #(.NUM_M(4), .MAX_BURST(MB), .PRIO_MASK(4'b0000)) u_flat (
      .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .gnt_o(g1), .gnt_id_o(id1),
      .gnt_valid_o(v1), .hold_o(h1), .burst_cnt_o(b1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int win(input logic [3:0] r, input logic [3:0] m, input int p);
      for (int i = 0; i < 4; i++) if (r[i] && m[i]) return i;
      for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
      return -1;
   endfunction

   task automatic model(input int k, input logic [3:0] r, input logic [3:0] l, input logic rs,
                        output exp_t x);
      int o, w;
      logic [3:0] om, rest;
      if (rs) begin
         own[k] = -1; cnt[k] = 0; ptr[k] = 0; lid[k] = 0;
      end else if (own[k] < 0) begin
         w = win(r, mask[k], ptr[k]);
         if (w >= 0) begin own[k] = w; cnt[k] = 1; lid[k] = w; end
      end else begin
         o = own[k];
         om = 4'b0001 << o;
         rest = r & ~om;
         if (r[o] && (l[o] || !((!mask[k][o] && (r & mask[k]) != 0) || (cnt[k] == MB && rest != 0)))) begin
            cnt[k] = cnt[k] < MB ? cnt[k] + 1 : MB;
         end else begin
            w = win(rest, mask[k], ptr[k]);
            ptr[k] = (o + 1) % 4;
            if (w >= 0) begin own[k] = w; cnt[k] = 1; lid[k] = w; end
            else begin own[k] = -1; cnt[k] = 0; end
         end
      end
      x.gnt = own[k] >= 0 ? 4'b0001 << own[k] : 4'b0000;
      x.id = 2'(lid[k]);
      x.vld = own[k] >= 0;
      x.bc = 3'(cnt[k]);
      x.hold = rs ? 4'b0000 : r & ~x.gnt;
   endtask

   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic rs);
      exp_t x;
      @(negedge clk);
      req_i = r;
      lock_i = l;
      rst = rs;
      model(0, r, l, rs, x);
      q0.push_back(x);
      model(1, r, l, rs, x);
      q1.push_back(x);
   endtask

   task automatic repeat_cyc(input int n, input logic [3:0] r, input logic [3:0] l);
      for (int i = 0; i < n; i++) cyc(r, l, 1'b0);
   endtask

   task automatic check(input string name, input exp_t act, input exp_t exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s t=%0t: got gnt=%b id=%0d vld=%b bc=%0d hold=%b, expected gnt=%b id=%0d vld=%b bc=%0d hold=%b",
                  name, $time, act.gnt, act.id, act.vld, act.bc, act.hold,
                  exp.gnt, exp.id, exp.vld, exp.bc, exp.hold);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         check("prio_arb", {g0, id0, v0, b0, h0}, e);
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         check("flat_arb", {g1, id1, v1, b1, h1}, e);
      end
   end

   initial begin
      mask[0] = 4'b1100;
      mask[1] = 4'b0000;
      rst = 1'b1;
      req_i = '0;
      lock_i = '0;
      cyc(4'b0000, 4'b0000, 1'b1);
      cyc(4'b0000, 4'b0000, 1'b1);
      repeat_cyc(8, 4'b0011, 4'b0000);
      cyc(4'b0000, 4'b0000, 1'b1);
      repeat_cyc(1, 4'b0001, 4'b0000);
      repeat_cyc(10, 4'b0111, 4'b0001);
      repeat_cyc(2, 4'b0111, 4'b0000);
      cyc(4'b0000, 4'b0000, 1'b1);
      repeat_cyc(1, 4'b0010, 4'b0000);
      repeat_cyc(2, 4'b1010, 4'b0000);
      repeat_cyc(2, 4'b0000, 4'b0000);
      repeat_cyc(2, 4'b1100, 4'b1000);
      cyc(4'b0000, 4'b0000, 1'b1);
      repeat_cyc(20, 4'b1111, 4'b0000);
      cyc(4'b0000, 4'b0000, 1'b1);
      repeat_cyc(2, 4'b0101, 4'b0000);
      repeat_cyc(2, 4'b0100, 4'b0000);
      repeat_cyc(2, 4'b0000, 4'b0000);
      repeat_cyc(1, 4'b0010, 4'b0000);
      repeat_cyc(1, 4'b0011, 4'b0000);
      repeat_cyc(3, 4'b0100, 4'b0000);
      cyc(4'b0111, 4'b0100, 1'b1);
      repeat_cyc(3, 4'b0011, 4'b0000);
      for (int i = 0; i < 2000; i++) begin
         cyc(4'($urandom), $urandom_range(0, 7) == 0 ? 4'($urandom) : 4'b0000,
             $urandom_range(0, 199) == 0);
      end
      @(negedge clk);
      @(negedge clk);
      if (q0.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d/%0d pending, expected 0/0", q0.size(), q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
